// File: rtl/mem2io_ctrl.sv
// LC-3 memory/IO bridge: sequences async SRAM reads/writes from the control unit's
// active-low strobes and redirects IO_ADDR to the switches / hex display register.
module mem2io_ctrl #(
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_WAIT = 1,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic [15:0] Switches,
    input  logic [15:0] SRAM_DQ_I,
    output logic [15:0] Data_to_CPU,
    output logic        Rd_valid,
    output logic        Wr_done,
    output logic [15:0] HEX_Data,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [15:0] SRAM_DQ_O,
    output logic        SRAM_DQ_OE
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RELEASE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [15:0]        data_to_cpu_d, hex_data_d, dq_o_d;
    logic [19:0]        sram_addr_d;
    logic               rd_valid_d, wr_done_d;
    logic               ce_n_d, oe_n_d, we_n_d, bytes_n_d, dq_oe_d;
    logic               rd_req, wr_req, is_io;

    assign rd_req = !Mem_CE && !Mem_OE &&  Mem_WE;
    assign wr_req = !Mem_CE &&  Mem_OE && !Mem_WE;
    assign is_io  = (ADDR == IO_ADDR);

    // Next-state and next-output logic; every register holds unless a state moves it.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        data_to_cpu_d = Data_to_CPU;
        hex_data_d    = HEX_Data;
        dq_o_d        = SRAM_DQ_O;
        sram_addr_d   = SRAM_ADDR;
        rd_valid_d    = 1'b0;
        wr_done_d     = 1'b0;
        ce_n_d        = SRAM_CE_N;
        oe_n_d        = SRAM_OE_N;
        we_n_d        = SRAM_WE_N;
        bytes_n_d     = SRAM_UB_N;
        dq_oe_d       = SRAM_DQ_OE;

        case (state)
            IDLE: begin
                if (rd_req && is_io) begin
                    data_to_cpu_d = Switches;
                    rd_valid_d    = 1'b1;
                    state_d       = RELEASE;
                end else if (rd_req) begin
                    sram_addr_d = {4'b0000, ADDR};
                    ce_n_d      = 1'b0;
                    oe_n_d      = 1'b0;
                    bytes_n_d   = 1'b0;
                    cnt_d       = CNT_W'(READ_WAIT - 1);
                    state_d     = RD_WAIT;
                end else if (wr_req && is_io) begin
                    hex_data_d = Data_from_CPU;
                    wr_done_d  = 1'b1;
                    state_d    = RELEASE;
                end else if (wr_req) begin
                    sram_addr_d = {4'b0000, ADDR};
                    dq_o_d      = Data_from_CPU;
                    dq_oe_d     = 1'b1;
                    ce_n_d      = 1'b0;
                    bytes_n_d   = 1'b0;
                    we_n_d      = 1'b1;
                    state_d     = WR_SETUP;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    data_to_cpu_d = SRAM_DQ_I;
                    rd_valid_d    = 1'b1;
                    ce_n_d        = 1'b1;
                    oe_n_d        = 1'b1;
                    bytes_n_d     = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = CNT_W'(WRITE_WAIT);
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    we_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                ce_n_d    = 1'b1;
                bytes_n_d = 1'b1;
                dq_oe_d   = 1'b0;
                wr_done_d = 1'b1;
                state_d   = RELEASE;
            end
            RELEASE: begin
                // One access per strobe assertion: wait for the control unit to let go.
                if (Mem_OE && Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            Data_to_CPU <= '0;
            HEX_Data    <= '0;
            SRAM_DQ_O   <= '0;
            SRAM_ADDR   <= '0;
            Rd_valid    <= 1'b0;
            Wr_done     <= 1'b0;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
            SRAM_LB_N   <= 1'b1;
            SRAM_DQ_OE  <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            Data_to_CPU <= data_to_cpu_d;
            HEX_Data    <= hex_data_d;
            SRAM_DQ_O   <= dq_o_d;
            SRAM_ADDR   <= sram_addr_d;
            Rd_valid    <= rd_valid_d;
            Wr_done     <= wr_done_d;
            SRAM_CE_N   <= ce_n_d;
            SRAM_OE_N   <= oe_n_d;
            SRAM_WE_N   <= we_n_d;
            SRAM_UB_N   <= bytes_n_d;
            SRAM_LB_N   <= bytes_n_d;
            SRAM_DQ_OE  <= dq_oe_d;
        end
    end

endmodule

// File: tb/tb_mem2io_ctrl.sv
// Directed bench for mem2io_ctrl: a transaction table run against a small SRAM model,
// plus hand-written reset and idle sequences.
module tb_mem2io_ctrl;

    localparam int WIN = 10;

    logic        Clk, Reset;
    logic        Mem_CE, Mem_OE, Mem_WE;
    logic [15:0] ADDR, Data_from_CPU, Switches, SRAM_DQ_I;
    logic [15:0] Data_to_CPU, HEX_Data, SRAM_DQ_O;
    logic        Rd_valid, Wr_done;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_OE;

    int total = 0;
    int bad   = 0;

    mem2io_ctrl #(.READ_WAIT(1), .WRITE_WAIT(1), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .Switches(Switches),
        .SRAM_DQ_I(SRAM_DQ_I), .Data_to_CPU(Data_to_CPU),
        .Rd_valid(Rd_valid), .Wr_done(Wr_done), .HEX_Data(HEX_Data),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Async SRAM model: writes while CE/WE low with bus driven, reads combinationally.
    logic [15:0] mem [0:65535];
    always @(posedge Clk) begin
        if (Reset)
            mem[16'h0040] <= 16'hBEEF;
        else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE)
            mem[SRAM_ADDR[15:0]] <= SRAM_DQ_O;
    end
    assign SRAM_DQ_I = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[15:0]] : 16'h0000;

    typedef struct {
        logic        ce, oe, we;
        logic [15:0] addr, wdata, sw;
        int          hold;
        int          e_rd, e_wr, e_oe, e_we, e_ce, e_dqoe, e_idx;
        logic [15:0] e_dout, e_hex;
        logic [19:0] e_saddr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Apply one request, watch WIN cycles, then compare counts and final registers.
    task automatic run_vec(input vec_t v, input int k);
        int n_rd = 0, n_wr = 0, n_oe = 0, n_we = 0, n_ce = 0, n_dqoe = 0;
        int first = -1, viol = 0;
        logic prev_ce_n = 1'b1;
        logic [19:0] pa = '0;
        logic [15:0] pd = '0;
        @(negedge Clk);
        Mem_CE = v.ce; Mem_OE = v.oe; Mem_WE = v.we;
        ADDR = v.addr; Data_from_CPU = v.wdata; Switches = v.sw;
        for (int i = 0; i < WIN; i++) begin
            @(negedge Clk);
            if (!SRAM_OE_N) n_oe++;
            if (!SRAM_WE_N) n_we++;
            if (!SRAM_CE_N) n_ce++;
            if (SRAM_DQ_OE) n_dqoe++;
            if (Rd_valid)   n_rd++;
            if (Wr_done)    n_wr++;
            if ((Rd_valid || Wr_done) && first < 0) first = i;
            if (!SRAM_OE_N && !SRAM_WE_N) viol++;
            if (!SRAM_WE_N && (prev_ce_n || !SRAM_DQ_OE)) viol++;
            if (!SRAM_CE_N && !prev_ce_n && (SRAM_ADDR !== pa || SRAM_DQ_O !== pd)) viol++;
            if (SRAM_UB_N !== SRAM_CE_N || SRAM_LB_N !== SRAM_CE_N) viol++;
            prev_ce_n = SRAM_CE_N; pa = SRAM_ADDR; pd = SRAM_DQ_O;
            if (i + 1 >= v.hold) begin
                Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
            end
        end
        chk($sformatf("v%0d_rd_pulses", k), n_rd, v.e_rd);
        chk($sformatf("v%0d_wr_pulses", k), n_wr, v.e_wr);
        chk($sformatf("v%0d_oe_cycles", k), n_oe, v.e_oe);
        chk($sformatf("v%0d_we_cycles", k), n_we, v.e_we);
        chk($sformatf("v%0d_ce_cycles", k), n_ce, v.e_ce);
        chk($sformatf("v%0d_dqoe_cycles", k), n_dqoe, v.e_dqoe);
        chk($sformatf("v%0d_pulse_cycle", k), first, v.e_idx);
        chk($sformatf("v%0d_violations", k), viol, 0);
        chk($sformatf("v%0d_data_to_cpu", k), 32'(Data_to_CPU), 32'(v.e_dout));
        chk($sformatf("v%0d_hex", k), 32'(HEX_Data), 32'(v.e_hex));
        chk($sformatf("v%0d_sram_addr", k), 32'(SRAM_ADDR), 32'(v.e_saddr));
    endtask

    initial begin
        int n_low, n_pulse;
        //          ce    oe    we    addr      wdata     sw        hold rd wr oe we ce dqoe idx  dout      hex       saddr
        vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 2,   1, 0, 1, 0, 1, 0,   1,  16'hBEEF, 16'h0000, 20'h00040};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0100, 16'h1234, 16'h0000, 2,   0, 1, 0, 2, 4, 4,   4,  16'hBEEF, 16'h0000, 20'h00100};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'h0000, 4,   1, 0, 1, 0, 1, 0,   1,  16'h1234, 16'h0000, 20'h00100};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h00A5, 2,   1, 0, 0, 0, 0, 0,   0,  16'h00A5, 16'h0000, 20'h00100};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0C0D, 16'h00A5, 3,   0, 1, 0, 0, 0, 0,   0,  16'h00A5, 16'h0C0D, 20'h00100};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 3,   0, 0, 0, 0, 0, 0,  -1,  16'h00A5, 16'h0C0D, 20'h00100};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 3,   0, 0, 0, 0, 0, 0,  -1,  16'h00A5, 16'h0C0D, 20'h00100};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h0041, 16'h9999, 16'h0000, 3,   0, 0, 0, 0, 0, 0,  -1,  16'h00A5, 16'h0C0D, 20'h00100};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h0041, 16'h5A5A, 16'h0000, 1,   0, 1, 0, 2, 4, 4,   4,  16'h00A5, 16'h0C0D, 20'h00041};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 16'h0041, 16'h0000, 16'h0000, 2,   1, 0, 1, 0, 1, 0,   1,  16'h5A5A, 16'h0C0D, 20'h00041};

        Reset = 1'b1; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        ADDR = '0; Data_from_CPU = '0; Switches = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Idle after reset: nothing strobed, nothing pulsed.
        n_low = 0; n_pulse = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (!SRAM_CE_N || !SRAM_OE_N || !SRAM_WE_N || !SRAM_UB_N || !SRAM_LB_N || SRAM_DQ_OE) n_low++;
            if (Rd_valid || Wr_done) n_pulse++;
        end
        chk("reset_strobes", n_low, 0);
        chk("reset_pulses", n_pulse, 0);
        chk("reset_data_to_cpu", 32'(Data_to_CPU), 0);
        chk("reset_hex", 32'(HEX_Data), 0);
        chk("reset_sram_addr", 32'(SRAM_ADDR), 0);
        chk("reset_dq_o", 32'(SRAM_DQ_O), 0);

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Reset in the middle of a write pulse.
        @(negedge Clk);
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; ADDR = 16'h0200; Data_from_CPU = 16'h7777;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_pre_we_low", 32'(SRAM_WE_N), 0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_we_n", 32'(SRAM_WE_N), 1);
        chk("rst_ce_n", 32'(SRAM_CE_N), 1);
        chk("rst_oe_n", 32'(SRAM_OE_N), 1);
        chk("rst_dq_oe", 32'(SRAM_DQ_OE), 0);
        chk("rst_hex", 32'(HEX_Data), 0);
        chk("rst_data_to_cpu", 32'(Data_to_CPU), 0);
        Reset = 1'b0; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;

        run_vec('{1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 2,
                  1, 0, 1, 0, 1, 0, 1, 16'hBEEF, 16'h0000, 20'h00040}, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
